pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised pipeline control block for the five-stage RISC-V core: it replaces the separate combinational forwarding and load-hazard units with one scoreboard that tracks in-flight register writes across a configurable number of post-decode stages. It drives all stall, flush and forwarding selects from one place. It adds variable-latency data memory (freeze on `i_mem_ready` low), external stall and flush, and a configurable load-result latency. It sits beside the datapath in the core top and only exchanges control signals with the stages.

## Interface
- `REG_W`, 5: register index width.
- `DEPTH`, 3: tracked stages after decode. Stage 0 = E, 1 = M, 2 = W, and so on.
- `LOAD_LAT`, 1: stages after E before load data can be forwarded. A load in stage k is forwardable only if k > `LOAD_LAT`.
- `FW_W`, `$clog2(DEPTH)`: forward select width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `i_issue_valid` in 1: decode holds a real instruction.
- `i_rs1`, `i_rs2` in `REG_W`: decode source indices.
- `i_rs1_used`, `i_rs2_used` in 1: the source is actually read.
- `i_rd` in `REG_W`: destination index.
- `i_wb_en` in 1: the instruction writes `i_rd`.
- `i_is_load` in 1: the instruction is a load.
- `i_branch_taken` in 1: the E-stage instruction redirects the PC.
- `i_mem_ready` in 1: data memory done. 0 freezes the whole pipeline.
- `i_ext_stall` in 1: hold F and D, insert a bubble into E.
- `i_ext_flush` in 1: kill F and D.
- `o_stall_f`, `o_stall_d` out 1: hold the fetch and decode registers.
- `o_flush_f`, `o_flush_d` out 1: clear the F/D and D/E registers. `o_flush_d` inserts a bubble into E.
- `o_hold_back` out 1: hold the E, M and W registers.
- `o_rs1_fw_sel`, `o_rs2_fw_sel` out `FW_W`: operand source for the E instruction. 0 = register file, k = stage k.
- `o_stall_cnt`, `o_flush_cnt`, `o_freeze_cnt` out 32: performance counters.

## Operation
- **Scoreboard.** Each stage k holds a record: valid, rd, wb_en, is_load. Stage 0 also holds rs1, rs2, rs1_used and rs2_used.
- **Producer match.** A stage is a producer for index r when `valid && wb_en && rd == r && r != 0`.
- **Forwarding.**
  - For each used E source, the select is the smallest k in 1..`DEPTH`-1 whose stage is a matching producer. Otherwise the select is 0.
  - A load producer at k ≤ `LOAD_LAT` never occurs here, because the load-use check has already prevented it.
- **Load-use hazard.** Raised when `i_issue_valid`, a used decode source matches a load producer in stage k, and k < `LOAD_LAT`.
- **Freeze.** When `i_mem_ready` = 0:
  - `o_hold_back`, `o_stall_f` and `o_stall_d` are 1.
  - The scoreboard holds.
  - No flush is issued.
  - The forward selects continue to reflect the held state.
- **Advance.** When `i_mem_ready` = 1:
  - Stage k+1 takes stage k. Stage `DEPTH`-1 retires.
  - Stage 0 takes the decode record only if `i_issue_valid` and none of branch flush, external flush, hazard or external stall is active. Otherwise stage 0 receives a bubble (valid = 0).
- **Priority on an advancing cycle, highest first.**
  1. Branch: `o_flush_f` = `o_flush_d` = 1, no stall.
  2. External flush: `o_flush_f` = `o_flush_d` = 1.
  3. Load-use hazard or external stall: `o_stall_f` = `o_stall_d` = 1, `o_flush_d` = 1.
  4. Otherwise: all control outputs are 0.
- **Branch under freeze.** A taken branch seen during a freeze acts on the first advancing cycle, because `i_branch_taken` is still asserted then.
- **Register-file timing.** The register file is write-first, so a write retiring from stage `DEPTH`-1 is visible to decode in the same cycle.

## Timing
- **Control outputs.** All control outputs are combinational from the current scoreboard and inputs. No added latency.
- **Scoreboard update.** The scoreboard updates on the rising edge of `clk`.
- **Load-use bubble.** With `LOAD_LAT` = 1, a load-use stall lasts exactly 1 cycle. In general it lasts `LOAD_LAT` − k cycles.
- **Reset.**
  - All records go invalid.
  - All outputs are 0, including forward selects of 0 and counters of 0.
  - Reset mid-freeze or mid-stall discards all tracked state.
  - The first cycle after reset advances normally.
- **Simultaneous events.**
  - `i_mem_ready` = 0 masks all other events.
  - A hazard together with a branch flush resolves as a flush, not a stall.
- **Counters.** Counters wrap at 2^32. They increment only on cycles where the corresponding condition is the one acted on.

## Configuration
- **`PIPELINE_HAZARD_CTRL_PERF_EN` defined.** The three counters are implemented:
  - `o_stall_cnt` counts load-use or external-stall cycles.
  - `o_flush_cnt` counts branch or external flushes.
  - `o_freeze_cnt` counts cycles with `i_mem_ready` = 0.
- **Undefined.** The ports remain and are driven constant 0. No counter flops are instantiated.

## Structure
- **Shared package `pipeline_pkg`.** Holds:
  - the stage record typedef;
  - the forward-select constant `FW_RF` = 0;
  - the `REG_W` default.
- **Sub-module `hazard_stage_tracker`.** Holds the `DEPTH`-entry record shift register with hold and bubble-insert control. The top computes matching, priority and counters.

## Test plan
- **Back-to-back ALU dependency.** `addi x5` then `add x6,x5,x5` → next cycle, with the add in E, both forward selects = 1. No stall.
- **Load-use.** `lw x7` then `sub x8,x7,x1` → one cycle with `o_stall_f`/`o_stall_d`/`o_flush_d` = 1. The following cycle `o_rs1_fw_sel` = 2 and `o_rs2_fw_sel` = 0.
- **x0 destination.** `lw x0` then `add x9,x0,x0` → no stall, forward selects 0.
- **Freeze during load.** `i_mem_ready` low for 3 cycles with a load in M → `o_hold_back` = 1 for exactly those 3 cycles. Records unchanged. `o_freeze_cnt` = 3.
- **Branch vs hazard.** `i_branch_taken` with a simultaneous load-use hazard → `o_flush_f` = `o_flush_d` = 1, stalls 0. `o_flush_cnt` +1. `o_stall_cnt` unchanged.
- **Parameter sweep.** `DEPTH` = 4, `LOAD_LAT` = 2: load immediately followed by a consumer → 2 stall cycles, then forward select 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default register-index width, the
// register-file forward select and the scoreboard stage record.
package pipeline_pkg;

  // Default register index width (32 architectural registers)
  localparam int REG_W_DEFAULT = 5;

  // Forward select value meaning "take the operand from the register file"
  localparam int FW_RF = 0;

  // One scoreboard entry; only stage 0 makes use of the source fields
  typedef struct packed {
    logic                     valid;
    logic                     wb_en;
    logic                     is_load;
    logic                     rs1_used;
    logic                     rs2_used;
    logic [REG_W_DEFAULT-1:0] rd;
    logic [REG_W_DEFAULT-1:0] rs1;
    logic [REG_W_DEFAULT-1:0] rs2;
  } stage_rec_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the datapath stages and the hazard controller.
// The datapath is the master (drives decode/stage status), the controller
// is the slave (drives stall/flush/forward selects and counters).
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int FW_W  = 2
);
  logic             i_issue_valid;
  logic [REG_W-1:0] i_rs1;
  logic [REG_W-1:0] i_rs2;
  logic             i_rs1_used;
  logic             i_rs2_used;
  logic [REG_W-1:0] i_rd;
  logic             i_wb_en;
  logic             i_is_load;
  logic             i_branch_taken;
  logic             i_mem_ready;
  logic             i_ext_stall;
  logic             i_ext_flush;
  logic             o_stall_f;
  logic             o_stall_d;
  logic             o_flush_f;
  logic             o_flush_d;
  logic             o_hold_back;
  logic [FW_W-1:0]  o_rs1_fw_sel;
  logic [FW_W-1:0]  o_rs2_fw_sel;
  logic [31:0]      o_stall_cnt;
  logic [31:0]      o_flush_cnt;
  logic [31:0]      o_freeze_cnt;

  modport master (
    output i_issue_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd,
           i_wb_en, i_is_load, i_branch_taken, i_mem_ready, i_ext_stall,
           i_ext_flush,
    input  o_stall_f, o_stall_d, o_flush_f, o_flush_d, o_hold_back,
           o_rs1_fw_sel, o_rs2_fw_sel, o_stall_cnt, o_flush_cnt, o_freeze_cnt
  );

  modport slave (
    input  i_issue_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd,
           i_wb_en, i_is_load, i_branch_taken, i_mem_ready, i_ext_stall,
           i_ext_flush,
    output o_stall_f, o_stall_d, o_flush_f, o_flush_d, o_hold_back,
           o_rs1_fw_sel, o_rs2_fw_sel, o_stall_cnt, o_flush_cnt, o_freeze_cnt
  );
endinterface

// File: rtl/hazard_stage_tracker.sv
// DEPTH-entry shift register of in-flight instruction records.
// Stage 0 is E; each advance moves stage k into k+1 and the last retires.
// hold freezes every entry; bubble loads an invalid record into stage 0.
module hazard_stage_tracker
  import pipeline_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type rec_t = stage_rec_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  bubble,
  input  rec_t                  in_rec,
  output rec_t [DEPTH-1:0]      stage_q
);

  rec_t [DEPTH-1:0] stage_r;

  // Shift records down the pipe unless the memory freeze holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else if (hold) begin
      stage_r <= stage_r;
    end else begin
      stage_r[0] <= bubble ? '0 : in_rec;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign stage_q = stage_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall / flush / forwarding control for the five-stage core.
// A scoreboard of in-flight writes (hazard_stage_tracker) feeds producer
// matching, load-use detection and the event priority resolved here.
// Optional macro PIPELINE_HAZARD_CTRL_PERF_EN implements the three
// performance counters; without it the counter ports are tied to zero.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W    = REG_W_DEFAULT,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int FW_W     = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             is_load;
    logic             rs1_used;
    logic             rs2_used;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } rec_t;

  // Stages that may still hold a load too young to forward from
  localparam int HZ_N = (LOAD_LAT < DEPTH) ? LOAD_LAT : DEPTH;

  rec_t             dec_rec_s;
  rec_t [DEPTH-1:0] stage_s;
  logic             hazard_s;
  logic             freeze_s;
  logic             redirect_s;
  logic             stall_req_s;
  logic             bubble_s;
  logic [FW_W-1:0]  rs1_sel_s;
  logic [FW_W-1:0]  rs2_sel_s;
  logic             stall_f_s;
  logic             stall_d_s;
  logic             flush_f_s;
  logic             flush_d_s;
  logic             hold_back_s;
  logic             unused_fields_s;

  function automatic logic is_producer(input rec_t rec, input logic [REG_W-1:0] idx);
    return rec.valid && rec.wb_en && (rec.rd == idx) && (idx != {REG_W{1'b0}});
  endfunction

  // Pack the decode-stage instruction into a scoreboard record
  always_comb begin
    dec_rec_s          = '0;
    dec_rec_s.valid    = bus.i_issue_valid;
    dec_rec_s.wb_en    = bus.i_wb_en;
    dec_rec_s.is_load  = bus.i_is_load;
    dec_rec_s.rs1_used = bus.i_rs1_used;
    dec_rec_s.rs2_used = bus.i_rs2_used;
    dec_rec_s.rd       = bus.i_rd;
    dec_rec_s.rs1      = bus.i_rs1;
    dec_rec_s.rs2      = bus.i_rs2;
  end

  // Load-use: a decode source depends on a load whose data is not yet forwardable
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < HZ_N; k++) begin
      hazard_s = hazard_s | (stage_s[k].is_load &&
                 ((bus.i_rs1_used && is_producer(stage_s[k], bus.i_rs1)) ||
                  (bus.i_rs2_used && is_producer(stage_s[k], bus.i_rs2))));
    end
    hazard_s = hazard_s & bus.i_issue_valid;
  end

  // Forward selects: scan oldest to youngest so the nearest producer wins
  always_comb begin
    rs1_sel_s = FW_W'(FW_RF);
    rs2_sel_s = FW_W'(FW_RF);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (stage_s[0].valid && stage_s[0].rs1_used &&
          is_producer(stage_s[k], stage_s[0].rs1)) begin
        rs1_sel_s = FW_W'(k);
      end else begin
        rs1_sel_s = rs1_sel_s;
      end
      if (stage_s[0].valid && stage_s[0].rs2_used &&
          is_producer(stage_s[k], stage_s[0].rs2)) begin
        rs2_sel_s = FW_W'(k);
      end else begin
        rs2_sel_s = rs2_sel_s;
      end
    end
  end

  assign freeze_s    = ~bus.i_mem_ready;
  assign redirect_s  = bus.i_branch_taken | bus.i_ext_flush;
  assign stall_req_s = hazard_s | bus.i_ext_stall;
  assign bubble_s    = ~bus.i_issue_valid | redirect_s | stall_req_s;

  // Event priority: freeze masks all, then branch/flush, then stall
  always_comb begin
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    flush_f_s   = 1'b0;
    flush_d_s   = 1'b0;
    hold_back_s = 1'b0;
    if (rst) begin
      hold_back_s = 1'b0;
    end else if (freeze_s) begin
      stall_f_s   = 1'b1;
      stall_d_s   = 1'b1;
      hold_back_s = 1'b1;
    end else if (redirect_s) begin
      flush_f_s = 1'b1;
      flush_d_s = 1'b1;
    end else if (stall_req_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_d_s = 1'b1;
    end else begin
      hold_back_s = 1'b0;
    end
  end

  hazard_stage_tracker #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .hold    (freeze_s),
    .bubble  (bubble_s),
    .in_rec  (dec_rec_s),
    .stage_q (stage_s)
  );

  // Source fields of later stages and young-stage load flags are carried but not inspected
  assign unused_fields_s = ^stage_s;

  assign bus.o_stall_f    = stall_f_s;
  assign bus.o_stall_d    = stall_d_s;
  assign bus.o_flush_f    = flush_f_s;
  assign bus.o_flush_d    = flush_d_s;
  assign bus.o_hold_back  = hold_back_s;
  assign bus.o_rs1_fw_sel = rst ? FW_W'(FW_RF) : rs1_sel_s;
  assign bus.o_rs2_fw_sel = rst ? FW_W'(FW_RF) : rs2_sel_s;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;
  logic [31:0] freeze_cnt_r;

  // Count the one event class acted on this cycle (wraps at 2^32)
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= 32'd0;
      flush_cnt_r  <= 32'd0;
      freeze_cnt_r <= 32'd0;
    end else if (freeze_s) begin
      freeze_cnt_r <= freeze_cnt_r + 32'd1;
    end else if (redirect_s) begin
      flush_cnt_r <= flush_cnt_r + 32'd1;
    end else if (stall_req_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.o_stall_cnt  = stall_cnt_r;
  assign bus.o_flush_cnt  = flush_cnt_r;
  assign bus.o_freeze_cnt = freeze_cnt_r;
`else
  assign bus.o_stall_cnt  = 32'd0;
  assign bus.o_flush_cnt  = 32'd0;
  assign bus.o_freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (DEPTH=3/LOAD_LAT=1 and
// DEPTH=4/LOAD_LAT=2) share one stimulus stream and are compared every
// cycle against an instruction-list reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       issue_v, rs1_u, rs2_u, wb_v, ld_v, br_v, mr_v, es_v, ef_v;
  logic [4:0] rs1_v, rs2_v, rd_v;

  pipeline_hazard_ctrl_if #(.REG_W(5), .FW_W(2)) bus_a ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .FW_W(2)) bus_b ();

  assign bus_a.i_issue_valid = issue_v;   assign bus_b.i_issue_valid = issue_v;
  assign bus_a.i_rs1 = rs1_v;             assign bus_b.i_rs1 = rs1_v;
  assign bus_a.i_rs2 = rs2_v;             assign bus_b.i_rs2 = rs2_v;
  assign bus_a.i_rs1_used = rs1_u;        assign bus_b.i_rs1_used = rs1_u;
  assign bus_a.i_rs2_used = rs2_u;        assign bus_b.i_rs2_used = rs2_u;
  assign bus_a.i_rd = rd_v;               assign bus_b.i_rd = rd_v;
  assign bus_a.i_wb_en = wb_v;            assign bus_b.i_wb_en = wb_v;
  assign bus_a.i_is_load = ld_v;          assign bus_b.i_is_load = ld_v;
  assign bus_a.i_branch_taken = br_v;     assign bus_b.i_branch_taken = br_v;
  assign bus_a.i_mem_ready = mr_v;        assign bus_b.i_mem_ready = mr_v;
  assign bus_a.i_ext_stall = es_v;        assign bus_b.i_ext_stall = es_v;
  assign bus_a.i_ext_flush = ef_v;        assign bus_b.i_ext_flush = ef_v;

  pipeline_hazard_ctrl #(.DEPTH(3), .LOAD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipeline_hazard_ctrl #(.DEPTH(4), .LOAD_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Observed outputs; control vector = {stall_f, stall_d, flush_f, flush_d, hold_back}
  logic [4:0]  ctl_o [2];
  logic [1:0]  fw1_o [2];
  logic [1:0]  fw2_o [2];
  logic [31:0] sc_o [2];
  logic [31:0] fc_o [2];
  logic [31:0] zc_o [2];
  assign ctl_o[0] = {bus_a.o_stall_f, bus_a.o_stall_d, bus_a.o_flush_f, bus_a.o_flush_d, bus_a.o_hold_back};
  assign ctl_o[1] = {bus_b.o_stall_f, bus_b.o_stall_d, bus_b.o_flush_f, bus_b.o_flush_d, bus_b.o_hold_back};
  assign fw1_o[0] = bus_a.o_rs1_fw_sel;   assign fw1_o[1] = bus_b.o_rs1_fw_sel;
  assign fw2_o[0] = bus_a.o_rs2_fw_sel;   assign fw2_o[1] = bus_b.o_rs2_fw_sel;
  assign sc_o[0] = bus_a.o_stall_cnt;     assign sc_o[1] = bus_b.o_stall_cnt;
  assign fc_o[0] = bus_a.o_flush_cnt;     assign fc_o[1] = bus_b.o_flush_cnt;
  assign zc_o[0] = bus_a.o_freeze_cnt;    assign zc_o[1] = bus_b.o_freeze_cnt;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Reference model: in-flight instructions indexed by age (0 = in E)
  typedef struct {
    bit v; bit wb; bit ld; bit u1; bit u2;
    int rd; int r1; int r2;
  } mrec_t;

  mrec_t       pipe [2][4];
  mrec_t       empty_rec;
  int          depth_m [2];
  int          lat_m [2];
  int unsigned m_sc [2];
  int unsigned m_fc [2];
  int unsigned m_zc [2];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit m_prod(int i, int k, int r);
    return pipe[i][k].v && pipe[i][k].wb && (pipe[i][k].rd == r) && (r != 0);
  endfunction

  function automatic int m_fw(int i, bit used, int r);
    if (rst || !pipe[i][0].v || !used) return 0;
    for (int k = 1; k < depth_m[i]; k++) if (m_prod(i, k, r)) return k;
    return 0;
  endfunction

  function automatic bit m_haz(int i);
    if (!issue_v) return 1'b0;
    for (int k = 0; k < lat_m[i] && k < depth_m[i]; k++)
      if (pipe[i][k].ld && ((rs1_u && m_prod(i, k, int'(rs1_v))) ||
                            (rs2_u && m_prod(i, k, int'(rs2_v))))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] m_ctl(int i);
    if (rst)          return 5'b00000;
    if (!mr_v)        return 5'b11001;
    if (br_v || ef_v) return 5'b00110;
    if (m_haz(i) || es_v) return 5'b11010;
    return 5'b00000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ctl%0d", i), 32'(ctl_o[i]), 32'(m_ctl(i)));
      chk($sformatf("fw1_%0d", i), 32'(fw1_o[i]), 32'(m_fw(i, pipe[i][0].u1, pipe[i][0].r1)));
      chk($sformatf("fw2_%0d", i), 32'(fw2_o[i]), 32'(m_fw(i, pipe[i][0].u2, pipe[i][0].r2)));
      chk($sformatf("stall_cnt%0d", i), sc_o[i], PERF ? 32'(m_sc[i]) : 32'd0);
      chk($sformatf("flush_cnt%0d", i), fc_o[i], PERF ? 32'(m_fc[i]) : 32'd0);
      chk($sformatf("freeze_cnt%0d", i), zc_o[i], PERF ? 32'(m_zc[i]) : 32'd0);
    end
  endtask

  task automatic drv(input bit v, input int a, input int b, input bit ua, input bit ub,
                     input int d, input bit w, input bit l, input bit bt,
                     input bit m, input bit s, input bit f);
    issue_v = v; rs1_v = 5'(a); rs2_v = 5'(b); rs1_u = ua; rs2_u = ub;
    rd_v = 5'(d); wb_v = w; ld_v = l; br_v = bt; mr_v = m; es_v = s; ef_v = f;
    #1;
  endtask

  // Clock edge plus model advance, using the inputs that were live at the edge
  task automatic tick();
    mrec_t nr;
    bit    h;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) pipe[i][k] = empty_rec;
        m_sc[i] = 0; m_fc[i] = 0; m_zc[i] = 0;
      end else begin
        h = m_haz(i);
        if (!mr_v) m_zc[i]++;
        else if (br_v || ef_v) m_fc[i]++;
        else if (h || es_v) m_sc[i]++;
        if (mr_v) begin
          for (int k = depth_m[i] - 1; k >= 1; k--) pipe[i][k] = pipe[i][k-1];
          nr = empty_rec;
          if (issue_v && !br_v && !ef_v && !h && !es_v) begin
            nr.v = 1'b1; nr.wb = wb_v; nr.ld = ld_v; nr.u1 = rs1_u; nr.u2 = rs2_u;
            nr.rd = int'(rd_v); nr.r1 = int'(rs1_v); nr.r2 = int'(rs2_v);
          end
          pipe[i][0] = nr;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all(); tick();
    end
  endtask

  initial begin
    depth_m[0] = 3; lat_m[0] = 1;
    depth_m[1] = 4; lat_m[1] = 2;

    // Reset: first edge clears the flops, second cycle is checked
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("rst_ctl_a", 32'(ctl_o[0]), 32'd0);
    chk("rst_fw1_a", 32'(fw1_o[0]), 32'd0);
    tick();
    rst = 1'b0;

    // addi x5 ; add x6,x5,x5 -> both selects 1, no stall
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0); check_all(); tick();
    drv(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0); check_all();
    chk("alu_ctl_a", 32'(ctl_o[0]), 32'd0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("alu_fw1_a", 32'(fw1_o[0]), 32'd1);
    chk("alu_fw2_a", 32'(fw2_o[0]), 32'd1); tick();
    idle(4);

    // lw x7 ; sub x8,x7,x1 -> one stall cycle, then rs1 select 2
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0); check_all(); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0); check_all();
    chk("lu_stall_a", 32'(ctl_o[0]), 32'h1a); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0); check_all();
    chk("lu_issue_a", 32'(ctl_o[0]), 32'd0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("lu_fw1_a", 32'(fw1_o[0]), 32'd2);
    chk("lu_fw2_a", 32'(fw2_o[0]), 32'd0); tick();
    idle(4);

    // lw x0 ; add x9,x0,x0 -> no stall, selects 0
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0); check_all(); tick();
    drv(1, 0, 0, 1, 1, 9, 1, 0, 0, 1, 0, 0); check_all();
    chk("x0_ctl_a", 32'(ctl_o[0]), 32'd0);
    chk("x0_ctl_b", 32'(ctl_o[1]), 32'd0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("x0_fw1_a", 32'(fw1_o[0]), 32'd0);
    chk("x0_fw2_a", 32'(fw2_o[0]), 32'd0); tick();
    idle(4);

    // Load in M, memory not ready for 3 cycles
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0); check_all(); tick();
    idle(1);
    for (int j = 0; j < 3; j++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check_all();
      chk("frz_ctl_a", 32'(ctl_o[0]), 32'h19); tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("frz_end_a", 32'(ctl_o[0]), 32'd0);
    chk("frz_cnt_a", zc_o[0], PERF ? 32'd3 : 32'd0); tick();
    idle(4);

    // Taken branch together with a load-use hazard resolves as a flush
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0); check_all(); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 1, 1, 0, 0); check_all();
    chk("brh_ctl_a", 32'(ctl_o[0]), 32'h06); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("brh_flush_cnt_a", fc_o[0], PERF ? 32'd1 : 32'd0);
    chk("brh_stall_cnt_a", sc_o[0], PERF ? 32'd1 : 32'd0); tick();
    idle(4);

    // DEPTH=4 / LOAD_LAT=2: two stall cycles, then select 3
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0, 0); check_all(); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0); check_all();
    chk("sw_stall1_b", 32'(ctl_o[1]), 32'h1a); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0); check_all();
    chk("sw_stall2_b", 32'(ctl_o[1]), 32'h1a); tick();
    drv(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 0, 0); check_all();
    chk("sw_issue_b", 32'(ctl_o[1]), 32'd0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_all();
    chk("sw_fw1_b", 32'(fw1_o[1]), 32'd3);
    chk("sw_fw2_b", 32'(fw2_o[1]), 32'd0); tick();
    idle(4);

    // Randomized traffic over a small register window to provoke matches
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      drv($urandom_range(9) < 8, $urandom_range(7), $urandom_range(7),
          $urandom_range(1), $urandom_range(1), $urandom_range(7),
          $urandom_range(3) != 0, $urandom_range(2) == 0,
          $urandom_range(9) == 0, $urandom_range(4) != 0,
          $urandom_range(9) == 0, $urandom_range(19) == 0);
      check_all();
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
